dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding request slave with fixed latency.
// A request (nonzero rmask or wmask) is accepted when IDLE or in the response
// cycle. At the accept edge the pre-write word is captured and the masked byte
// lanes are written. dmem_resp pulses LATENCY cycles later.
// Optional feature macro: DMEM_ALIGN_CHK_EN (misaligned-mask detection -> dmem_err).
// Ports:
//   clk, rst            clock, async active-high reset
//   dmem_addr[31:0]     byte address (word index from bits [2 +: clog2(DEPTH_WORDS)])
//   dmem_rmask[3:0]     read byte mask
//   dmem_wmask[3:0]     write byte mask
//   dmem_wdata[31:0]    write data, lanes aligned to the word
//   dmem_rdata[31:0]    captured full word, valid with dmem_resp, held otherwise
//   dmem_resp           one-cycle response pulse
//   dmem_err            access error, qualified by dmem_resp
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        dmem_err
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               resp_q, resp_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [31:0]        mem [DEPTH_WORDS];

    logic               req_c;
    logic               accept_c;
    logic               misalign_c;
    logic [AW-1:0]      idx_c;
    logic               unused_addr;

    // High address bits alias; byte offset never indexes storage.
    assign idx_c       = dmem_addr[2 +: AW];
    assign unused_addr = ^{dmem_addr[31:AW+2], dmem_addr[1:0]};

    assign req_c    = (dmem_rmask != 4'b0) || (dmem_wmask != 4'b0);
    // resp_q high means this is the final BUSY cycle, so a new request may overlap it.
    assign accept_c = req_c && !rst && ((state_q == IDLE) || resp_q);

`ifdef DMEM_ALIGN_CHK_EN
    // Nonzero mask must be a naturally shaped byte/half/word lane set that
    // does not reach below the byte offset.
    function automatic logic mask_bad(input logic [3:0] m, input logic [1:0] off);
        logic       legal;
        logic [3:0] low;
        case (m)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: legal = 1'b1;
            default:                   legal = 1'b0;
        endcase
        case (off)
            2'd0:    low = 4'b0000;
            2'd1:    low = 4'b0001;
            2'd2:    low = 4'b0011;
            default: low = 4'b0111;
        endcase
        return (m != 4'b0) && (!legal || ((m & low) != 4'b0));
    endfunction

    assign misalign_c = mask_bad(dmem_rmask, dmem_addr[1:0]) ||
                        mask_bad(dmem_wmask, dmem_addr[1:0]);
`else
    assign misalign_c = 1'b0;
`endif

    // State and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state, latency count and read capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept_c) begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
            rdata_d = misalign_c ? 32'h0 : mem[idx_c];
            err_d   = misalign_c;
        end else if (state_q == BUSY) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                state_d = IDLE;
            end
        end
        resp_d = (state_d == BUSY) && (cnt_d == '0);
    end

    // Storage is not reset; masked lanes commit at the accept edge.
    always_ff @(posedge clk) begin
        if (accept_c && !misalign_c) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_wmask[i]) begin
                    mem[idx_c][8*i +: 8] <= dmem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign dmem_rdata = rdata_q;
    assign dmem_resp  = resp_q;
    assign dmem_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        dmem_err;

    int n_vec;
    int n_bad;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .dmem_err   (dmem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic [31:0] a, input logic [3:0] r, input logic [3:0] w,
                           input logic [31:0] d);
        dmem_addr  = a;
        dmem_rmask = r;
        dmem_wmask = w;
        dmem_wdata = d;
    endtask

    task automatic clr_req();
        set_req(32'h0, 4'h0, 4'h0, 32'h0);
    endtask

    // One isolated transaction: accept, resp exactly two cycles later, then held data.
    task automatic txn(input string name, input vec_t v, input logic exp_err);
        @(negedge clk);
        set_req(v.addr, v.rmask, v.wmask, v.wdata);
        @(posedge clk);
        @(negedge clk);
        clr_req();
        chk({name, ".resp_c1"}, 32'(dmem_resp), 32'h0);
        @(negedge clk);
        chk({name, ".resp_c2"}, 32'(dmem_resp), 32'h1);
        chk({name, ".err"}, 32'(dmem_err), 32'(exp_err));
        if (v.chk_rd) chk({name, ".rdata"}, dmem_rdata, v.exp_rdata);
        @(negedge clk);
        chk({name, ".resp_c3"}, 32'(dmem_resp), 32'h0);
        if (v.chk_rd) chk({name, ".rdata_hold"}, dmem_rdata, v.exp_rdata);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, ".resp"},  32'(dmem_resp), 32'h0);
        chk({name, ".rdata"}, dmem_rdata,     32'h0);
        chk({name, ".err"},   32'(dmem_err),  32'h0);
    endtask

    initial begin
        vec_t v;
        n_vec = 0;
        n_bad = 0;

        vecs[0]  = '{32'h0000_0010, 4'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{32'h0000_0010, 4'hF, 4'h0, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[2]  = '{32'h0000_0011, 4'h0, 4'h2, 32'h0000_AA00, 1'b0, 32'h0};
        vecs[3]  = '{32'h0000_0010, 4'hF, 4'h0, 32'h0,         1'b1, 32'hDEAD_AAEF};
        vecs[4]  = '{32'h0000_0020, 4'h0, 4'hF, 32'h1234_5678, 1'b0, 32'h0};
        vecs[5]  = '{32'h0000_0020, 4'hF, 4'h1, 32'h0000_00FF, 1'b1, 32'h1234_5678};
        vecs[6]  = '{32'h0000_0020, 4'hF, 4'h0, 32'h0,         1'b1, 32'h1234_56FF};
        vecs[7]  = '{32'h0000_0410, 4'hF, 4'h0, 32'h0,         1'b1, 32'hDEAD_AAEF};
        vecs[8]  = '{32'h0000_0013, 4'h8, 4'h0, 32'h0,         1'b1, 32'hDEAD_AAEF};
        vecs[9]  = '{32'h0000_0030, 4'h0, 4'hF, 32'h0000_0000, 1'b0, 32'h0};
        vecs[10] = '{32'h0000_0032, 4'h0, 4'hC, 32'hCAFE_0000, 1'b0, 32'h0};
        vecs[11] = '{32'h0000_0030, 4'hF, 4'h0, 32'h0,         1'b1, 32'hCAFE_0000};

        rst = 1'b1;
        clr_req();
        #2;
        chk_reset_outputs("rst_hi");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst_rel");

        for (int i = 0; i < NV; i++) begin
            txn($sformatf("vec%0d", i), vecs[i], 1'b0);
        end

        // Request while BUSY is ignored; request in the resp cycle is accepted.
        @(negedge clk);
        set_req(32'h10, 4'hF, 4'h0, 32'h0);
        @(negedge clk);
        set_req(32'h10, 4'h0, 4'hF, 32'h1111_1111);
        chk("b2b.resp_c1", 32'(dmem_resp), 32'h0);
        @(negedge clk);
        set_req(32'h20, 4'hF, 4'h0, 32'h0);
        chk("b2b.resp_c2", 32'(dmem_resp), 32'h1);
        chk("b2b.rdata_c2", dmem_rdata, 32'hDEAD_AAEF);
        @(negedge clk);
        clr_req();
        chk("b2b.resp_c3", 32'(dmem_resp), 32'h0);
        @(negedge clk);
        chk("b2b.resp_c4", 32'(dmem_resp), 32'h1);
        chk("b2b.rdata_c4", dmem_rdata, 32'h1234_56FF);
        @(negedge clk);
        chk("b2b.resp_c5", 32'(dmem_resp), 32'h0);
        v = '{32'h10, 4'hF, 4'h0, 32'h0, 1'b1, 32'hDEAD_AAEF};
        txn("ignored_wr", v, 1'b0);

        // Back-to-back read of a word just written sees the new data.
        @(negedge clk);
        set_req(32'h40, 4'h0, 4'hF, 32'h5A5A_5A5A);
        @(negedge clk);
        clr_req();
        @(negedge clk);
        set_req(32'h40, 4'hF, 4'h0, 32'h0);
        chk("wr_rd.resp_w", 32'(dmem_resp), 32'h1);
        @(negedge clk);
        clr_req();
        @(negedge clk);
        chk("wr_rd.resp_r", 32'(dmem_resp), 32'h1);
        chk("wr_rd.rdata", dmem_rdata, 32'h5A5A_5A5A);

        // Reset during BUSY abandons the read; rdata (nonzero before) clears.
        @(negedge clk);
        set_req(32'h20, 4'hF, 4'h0, 32'h0);
        @(negedge clk);
        clr_req();
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_busy");
        @(negedge clk);
        chk("rst_busy.resp_c2", 32'(dmem_resp), 32'h0);
        rst = 1'b0;
        set_req(32'h10, 4'hF, 4'h0, 32'h0);
        @(negedge clk);
        clr_req();
        chk("post_rst.resp_c1", 32'(dmem_resp), 32'h0);
        @(negedge clk);
        chk("post_rst.resp_c2", 32'(dmem_resp), 32'h1);
        chk("post_rst.rdata", dmem_rdata, 32'hDEAD_AAEF);
        @(negedge clk);
        chk("post_rst.resp_c3", 32'(dmem_resp), 32'h0);

`ifdef DMEM_ALIGN_CHK_EN
        v = '{32'h11, 4'h0, 4'h3, 32'h0000_FFFF, 1'b1, 32'h0};
        txn("misalign", v, 1'b1);
        v = '{32'h10, 4'hF, 4'h0, 32'h0, 1'b1, 32'hDEAD_AAEF};
        txn("misalign_nowr", v, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
